// File: rtl/hilo_acc_unit.sv
// HI/LO special-register pair with per-half direct writes, read bypass and a
// multiply-accumulate path that is either single-cycle or split into a low/high carry chain.
module hilo_acc_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter bit          ACC_SPLIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            wr_en_i,
    input  logic [DATA_W-1:0]     hi_i,
    input  logic [DATA_W-1:0]     lo_i,
    input  logic                  acc_valid_i,
    input  logic                  acc_sub_i,
    input  logic [2*DATA_W-1:0]   acc_op_i,
    output logic                  acc_ready_o,
    input  logic                  flush_i,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
    output logic                  busy_o
);

    typedef enum logic {IDLE = 1'b0, HIGH = 1'b1} state_t;

    state_t                state_r;
    logic [DATA_W-1:0]     hi_r;
    logic [DATA_W-1:0]     lo_r;
    logic [DATA_W-1:0]     shadow_r;
    logic [DATA_W-1:0]     op_hi_r;
    logic                  carry_r;
    logic                  sub_r;

    logic                  accept_s;
    logic [DATA_W:0]       lo_step_s;
    logic [DATA_W-1:0]     hi_step_s;
    logic [2*DATA_W-1:0]   full_step_s;

    // Low half: bit DATA_W is the carry-out for add, or the borrow (a < b) for subtract.
    function automatic logic [DATA_W:0] low_half(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic              sub);
        if (sub) begin
            return {1'b0, a} - {1'b0, b};
        end else begin
            return {1'b0, a} + {1'b0, b};
        end
    endfunction

    function automatic logic [DATA_W-1:0] high_half(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b,
                                                    input logic              cin,
                                                    input logic              sub);
        if (sub) begin
            return a - b - {{(DATA_W-1){1'b0}}, cin};
        end else begin
            return a + b + {{(DATA_W-1){1'b0}}, cin};
        end
    endfunction

    // Handshake, status and read bypass; everything reads as zero while in reset.
    always_comb begin
        acc_ready_o = 1'b0;
        busy_o      = 1'b0;
        hi_o        = {DATA_W{1'b0}};
        lo_o        = {DATA_W{1'b0}};
        if (rst) begin
            acc_ready_o = 1'b0;
        end else begin
            acc_ready_o = (state_r == IDLE) && (wr_en_i == 2'b00) && !flush_i;
            busy_o      = (state_r == HIGH);
            hi_o        = (wr_en_i[1] && !flush_i) ? hi_i : hi_r;
            lo_o        = (wr_en_i[0] && !flush_i) ? lo_i : lo_r;
        end
    end

    // Arithmetic for both accumulate flavours.
    always_comb begin
        accept_s    = acc_valid_i && acc_ready_o;
        lo_step_s   = low_half(lo_r, acc_op_i[DATA_W-1:0], acc_sub_i);
        hi_step_s   = high_half(hi_r, op_hi_r, carry_r, sub_r);
        if (acc_sub_i) begin
            full_step_s = {hi_r, lo_r} - acc_op_i;
        end else begin
            full_step_s = {hi_r, lo_r} + acc_op_i;
        end
    end

    // Register state; a flush in HIGH restores LO from the shadow copy taken at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            hi_r     <= {DATA_W{1'b0}};
            lo_r     <= {DATA_W{1'b0}};
            shadow_r <= {DATA_W{1'b0}};
            op_hi_r  <= {DATA_W{1'b0}};
            carry_r  <= 1'b0;
            sub_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!flush_i) begin
                        if (wr_en_i[1]) hi_r <= hi_i;
                        if (wr_en_i[0]) lo_r <= lo_i;
                        if (accept_s) begin
                            if (ACC_SPLIT) begin
                                shadow_r <= lo_r;
                                lo_r     <= lo_step_s[DATA_W-1:0];
                                carry_r  <= lo_step_s[DATA_W];
                                op_hi_r  <= acc_op_i[2*DATA_W-1:DATA_W];
                                sub_r    <= acc_sub_i;
                                state_r  <= HIGH;
                            end else begin
                                {hi_r, lo_r} <= full_step_s;
                            end
                        end
                    end
                end
                HIGH: begin
                    state_r <= IDLE;
                    if (flush_i) begin
                        lo_r <= shadow_r;
                    end else begin
                        // A direct HI write supersedes the pending high-half update.
                        hi_r <= wr_en_i[1] ? hi_i : hi_step_s;
                        if (wr_en_i[0]) lo_r <= lo_i;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed scoreboard bench for hilo_acc_unit: split build as main DUT, unsplit build alongside.
module tb_hilo_acc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wr_en;
    logic [31:0] hi_in, lo_in;
    logic        acc_valid, acc_sub, flush;
    logic [63:0] acc_op;
    logic        ready1, busy1, ready0, busy0;
    logic [31:0] hi1, lo1, hi0, lo0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        logic        ready;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hilo_acc_unit #(.DATA_W(32), .ACC_SPLIT(1'b1)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .hi_i(hi_in), .lo_i(lo_in),
        .acc_valid_i(acc_valid), .acc_sub_i(acc_sub), .acc_op_i(acc_op),
        .acc_ready_o(ready1), .flush_i(flush), .hi_o(hi1), .lo_o(lo1), .busy_o(busy1)
    );

    hilo_acc_unit #(.DATA_W(32), .ACC_SPLIT(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .hi_i(hi_in), .lo_i(lo_in),
        .acc_valid_i(acc_valid), .acc_sub_i(acc_sub), .acc_op_i(acc_op),
        .acc_ready_o(ready0), .flush_i(flush), .hi_o(hi0), .lo_o(lo0), .busy_o(busy0)
    );

    task automatic drive(input logic [1:0] w, input logic [31:0] h, input logic [31:0] l,
                         input logic v, input logic s, input logic [63:0] op, input logic f);
        wr_en = w; hi_in = h; lo_in = l; acc_valid = v; acc_sub = s; acc_op = op; flush = f;
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit sel, input logic [31:0] h,
                              input logic [31:0] l, input logic b, input logic r);
        exp_t e;
        e.tag = tag; e.sel = sel; e.hi = h; e.lo = l; e.busy = b; e.ready = r;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then compare against every queued expectation.
    task automatic check_now();
        exp_t e;
        logic [31:0] ah, al;
        logic ab, ar;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) begin
                ah = hi0; al = lo0; ab = busy0; ar = ready0;
            end else begin
                ah = hi1; al = lo1; ab = busy1; ar = ready1;
            end
            checks++;
            assert (ah === e.hi) else begin
                errors++;
                $error("FAIL %s hi_o observed=%h expected=%h", e.tag, ah, e.hi);
            end
            checks++;
            assert (al === e.lo) else begin
                errors++;
                $error("FAIL %s lo_o observed=%h expected=%h", e.tag, al, e.lo);
            end
            checks++;
            assert (ab === e.busy) else begin
                errors++;
                $error("FAIL %s busy_o observed=%b expected=%b", e.tag, ab, e.busy);
            end
            checks++;
            assert (ar === e.ready) else begin
                errors++;
                $error("FAIL %s acc_ready_o observed=%b expected=%b", e.tag, ar, e.ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b11, 32'hDEAD0000, 32'h0000BEEF, 1'b1, 1'b0, 64'h1, 1'b0);
        step(); step();
        expect_out("in_reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_now();
        idle();
        step();
        rst = 1'b0;
        expect_out("after_reset", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_now();

        // Direct write with bypass, then a LO-only write leaves HI visible.
        drive(2'b11, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 64'h0, 1'b0);
        expect_out("wr11_bypass", 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
        check_now();
        step(); idle();
        expect_out("wr11_stored", 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
        check_now();
        drive(2'b01, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 64'h0, 1'b0);
        expect_out("wr01_bypass", 1'b0, 32'h12345678, 32'h00000001, 1'b0, 1'b0);
        check_now();
        step(); idle();
        expect_out("wr01_stored", 1'b0, 32'h12345678, 32'h00000001, 1'b0, 1'b1);
        check_now();

        // Add with carry across the halves.
        drive(2'b11, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 64'h1, 1'b0);
        step(); idle();
        expect_out("add_k", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check_now();
        step();
        expect_out("add_k1", 1'b0, 32'h1, 32'h0, 1'b0, 1'b1);
        check_now();

        // Subtract with borrow, then 0 - 1 wraps.
        drive(2'b11, 32'h1, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 64'h1, 1'b0);
        step(); idle();
        expect_out("sub_k", 1'b0, 32'h1, 32'hFFFFFFFF, 1'b1, 1'b0);
        check_now();
        step();
        expect_out("sub_k1", 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        check_now();
        drive(2'b11, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 64'h1, 1'b0);
        step(); idle(); step();
        expect_out("sub_wrap", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        check_now();

        // Flush in HIGH restores LO and ignores same-cycle writes.
        drive(2'b11, 32'h5, 32'h80000000, 1'b0, 1'b0, 64'h0, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 64'h00000003_90000000, 1'b0);
        step();
        drive(2'b11, 32'hDEAD0000, 32'h0000BEEF, 1'b0, 1'b0, 64'h0, 1'b1);
        expect_out("flush_high", 1'b0, 32'h5, 32'h10000000, 1'b1, 1'b0);
        check_now();
        step(); idle();
        expect_out("flush_restored", 1'b0, 32'h5, 32'h80000000, 1'b0, 1'b1);
        check_now();

        // Flush in IDLE blocks both acceptance and direct writes for that cycle.
        drive(2'b11, 32'hDEAD0000, 32'h0000BEEF, 1'b1, 1'b0, 64'h1, 1'b1);
        expect_out("flush_idle", 1'b0, 32'h5, 32'h80000000, 1'b0, 1'b0);
        check_now();
        step(); idle();
        expect_out("flush_idle_after", 1'b0, 32'h5, 32'h80000000, 1'b0, 1'b1);
        check_now();

        // HI write in HIGH wins over the pending high-half update.
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 64'h00000001_80000000, 1'b0);
        step();
        drive(2'b10, 32'hAAAA0000, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        expect_out("hi_collide_bypass", 1'b0, 32'hAAAA0000, 32'h0, 1'b1, 1'b0);
        check_now();
        step(); idle();
        expect_out("hi_collide", 1'b0, 32'hAAAA0000, 32'h0, 1'b0, 1'b1);
        check_now();

        // LO write in HIGH: HI still completes with the stored carry (5 + 1 + 1).
        drive(2'b11, 32'h5, 32'h80000000, 1'b0, 1'b0, 64'h0, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 64'h00000001_80000000, 1'b0);
        step();
        drive(2'b01, 32'h0, 32'h00000055, 1'b0, 1'b0, 64'h0, 1'b0);
        step(); idle();
        expect_out("lo_collide", 1'b0, 32'h7, 32'h00000055, 1'b0, 1'b1);
        check_now();

        // Back-to-back requests: second one is held off while busy.
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 64'h1, 1'b0);
        step();
        expect_out("b2b_blocked", 1'b0, 32'h7, 32'h00000056, 1'b1, 1'b0);
        check_now();
        step();
        expect_out("b2b_ready", 1'b0, 32'h7, 32'h00000056, 1'b0, 1'b1);
        check_now();
        step(); idle(); step();
        expect_out("b2b_second", 1'b0, 32'h7, 32'h00000057, 1'b0, 1'b1);
        check_now();

        // Reset while in HIGH discards the partial result.
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 64'h00000003_FFFFFFFF, 1'b0);
        step(); idle();
        rst = 1'b1;
        expect_out("rst_in_high", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_now();
        step();
        rst = 1'b0;
        expect_out("rst_high_after", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check_now();

        // Unsplit build: the whole result lands in one edge with busy_o low.
        drive(2'b11, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 64'h1, 1'b0);
        step(); idle();
        expect_out("nosplit_add", 1'b1, 32'h1, 32'h0, 1'b0, 1'b1);
        check_now();
        drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 64'h1, 1'b0);
        step(); idle();
        expect_out("nosplit_sub", 1'b1, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
        check_now();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_acc_unit.md
Name: hilo_acc_unit

Overview:
- Parametrised HI/LO special-register pair for the EX/WB boundary.
- Supports per-half direct writes with read bypass, plus a multiply-accumulate path (MADD/MSUB style): HI:LO <= HI:LO ± operand.
- Accumulate is single-cycle or split into a two-cycle low/high carry chain to meet timing.
- Has a flush input that rolls back a speculative, in-flight accumulate.

Parameters:
- DATA_W, 32, width of each of HI and LO.
- ACC_SPLIT, 1. 0 = full 2*DATA_W add in one cycle. 1 = two-cycle split add with registered carry/borrow.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en_i  in  2  direct write enable; bit1 = HI, bit0 = LO
- hi_i  in  DATA_W  direct write data for HI
- lo_i  in  DATA_W  direct write data for LO
- acc_valid_i  in  1  accumulate request
- acc_sub_i  in  1  0 = add, 1 = subtract
- acc_op_i  in  2*DATA_W  accumulate operand; upper half applies to HI
- acc_ready_o  out  1  accumulate request accepted this cycle when high with acc_valid_i
- flush_i  in  1  squash same-cycle requests and any in-flight accumulate
- hi_o  out  DATA_W  HI read value
- lo_o  out  DATA_W  LO read value
- busy_o  out  1  accumulate in flight; hi_o is stale while high

Behaviour:
Reset:
- Reset is clk, synchronous, active-high (rst).
- On rst: HI = LO = 0, state = IDLE, carry = 0, shadow = 0.
- While rst is high: hi_o = lo_o = 0, acc_ready_o = 0, busy_o = 0.

Read path (combinational):
- hi_o = hi_i if wr_en_i[1] and not flush_i, else stored HI.
- lo_o follows the same rule with wr_en_i[0], lo_i and stored LO.
- A non-written half always shows its stored value, never 0.

Direct write:
- Applied at the clock edge for each enabled half, unless flush_i is high.

Accept rule:
- acc_ready_o = (state == IDLE) and wr_en_i == 0 and not flush_i.
- Accept occurs when acc_valid_i and acc_ready_o are both high.

ACC_SPLIT = 0:
- On accept edge: {HI, LO} <= {HI, LO} ± acc_op_i, modulo 2^(2*DATA_W).
- FSM stays IDLE; busy_o is always 0.

ACC_SPLIT = 1, two-state FSM (IDLE, HIGH):
- IDLE + accept, at edge k:
  - shadow <= LO.
  - LO <= LO ± op_lo.
  - carry <= carry-out of the add, or borrow (LO < op_lo, unsigned) for subtract.
  - op_hi and sub are registered; go to HIGH.
- HIGH, at edge k+1:
  - HI <= HI + op_hi + carry, or HI - op_hi - carry for subtract; go to IDLE.
- busy_o = (state == HIGH); acc_ready_o = 0 in HIGH.
- Full result is visible on hi_o/lo_o after edge k+1.
- Back-to-back accumulates are accepted every 2 cycles.

Collisions in HIGH:
- wr_en_i[1]: direct HI write wins; the pending high-half update is discarded; go to IDLE.
- wr_en_i[0] alone: LO is written; the HI completion still occurs using the stored carry.

Flush:
- In HIGH: LO <= shadow, HI unchanged, go to IDLE. This restores the exact pre-accumulate value. Any same-cycle wr_en_i is ignored.
- In IDLE: blocks acceptance and direct writes for that cycle only.

Reset mid-operation:
- rst in HIGH returns to IDLE with HI = LO = 0; the partial result is not preserved.

Arithmetic:
- Unsigned modular, wrap-around, no overflow flag. Signed MADD/MSUB is sign-extended by the producer into acc_op_i.

Test Plan:
1. Reset, then wr_en=11, hi=0x12345678, lo=0x9ABCDEF0 -> same cycle hi_o/lo_o bypass those values; after the edge they are stored. Next, wr_en=01, lo=0x1 -> hi_o remains 0x12345678 and lo_o=0x1 (not 0).
2. ACC_SPLIT=1, HI:LO=0x00000000_FFFFFFFF, acc add op=0x1:
   - after edge k: LO=0, busy_o=1, acc_ready_o=0.
   - after edge k+1: HI=0x00000001, busy_o=0.
3. HI:LO=0x00000001_00000000, acc_sub op=0x1 -> borrow propagates; result HI=0x00000000, LO=0xFFFFFFFF. Also 0 - 1 wraps to 0xFFFFFFFF_FFFFFFFF.
4. Accumulate accepted, flush_i in HIGH -> LO restored to its pre-accept value, HI unchanged, FSM in IDLE, acc_ready_o=1 next cycle.
5. Collisions in HIGH:
   - wr_en=10, hi=0xAAAA0000 -> HI=0xAAAA0000, accumulate high half dropped.
   - Repeat with wr_en=01 -> LO = written value, HI completes with the carry.
6. rst asserted in HIGH -> next cycle HI=LO=0, busy_o=0. ACC_SPLIT=0 build: the scenario 2 result appears in one edge with busy_o=0.
